slave_comm_rx: RTL
==================

Name: slave_comm_rx

Overview:
Receive end of the slave message link. The link is serialised by the slave transmitter as follows:
- SLAVE_MSG_CLK is the bit clock.
- FSX is the frame enable.
- Data is sent MSB first, one bit per bit clock.
- The frame is N data bytes followed by one CRC8 byte.

The block oversamples the link in clk_sys_i, deserialises the bytes and strips the CRC byte. It checks CRC8 (poly x^8+x^2+x+1, init 0xFF) and delivers bytes plus frame status to the message handler in the system domain.

Parameters:
- SYNC_STAGES, 2: synchroniser flops on SLAVE_MSG_CLK, FSX and RX; range 2-4.
- BYTE_NUM_W, 16: width of the received byte counter.

Ports:
- clk_sys_i  in  1  system clock; must be at least 4x SLAVE_MSG_CLK frequency.
- rst_i  in  1  synchronous, active-high reset on clk_sys_i.
- SLAVE_MSG_CLK  in  1  link bit clock (asynchronous).
- SLAVE_MSG_RX_FSX  in  1  frame enable; high for the whole frame.
- SLAVE_MSG_RX  in  1  serial data; changes on the falling edge of SLAVE_MSG_CLK.
- slave_rx_data_vld_o  out  1  one-cycle strobe for a payload byte.
- slave_rx_data_o  out  8  payload byte; valid with slave_rx_data_vld_o.
- slave_rx_frame_done_o  out  1  one-cycle strobe at end of frame.
- slave_rx_byte_num_o  out  BYTE_NUM_W  payload byte count; valid with frame_done.
- slave_rx_crc_err_o  out  1  CRC mismatch; valid with frame_done.
- slave_rx_frame_err_o  out  1  framing error; valid with frame_done.
- slave_rx_busy_o  out  1  high while in ST_RX.

Behaviour:
- Clocking and reset:
  - One clock (clk_sys_i); reset is synchronous and active-high (rst_i).
  - Every output resets to 0.
- Input conditioning:
  - SLAVE_MSG_CLK, FSX and RX each pass through SYNC_STAGES flops, then one extra register for edge detection.
  - clk_rise is a one-cycle strobe when the synchronised clock goes 0->1.
  - fsx_fall is the synchronised FSX going 1->0.
  - RX is sampled on clk_rise only, from the synchronised stage aligned with the clock stage.
- State machine:
  - ST_FLUSH (entered from reset):
    - Leave to ST_IDLE once the synchronised FSX is low.
    - This prevents locking onto the middle of a frame after a reset.
  - ST_IDLE:
    - On clk_rise with FSX high, go to ST_RX.
    - That same sample is bit 7 of byte 0.
    - Clear bit_cnt, shift register, byte count and pending flag; set crc = 0xFF.
  - ST_RX:
    - Each clk_rise with FSX high shifts RX into the LSB of sh[7:0].
    - bit_cnt is 3 bits and increments on each such sample.
    - On the 8th bit (bit_cnt wraps 7->0) the byte is complete:
      - If pend_vld = 1: output pend_byte with slave_rx_data_vld_o on the next cycle; crc = nextCRC8D8(pend_byte, crc); increment byte_num (saturates at all-ones).
      - Then pend_byte = new byte and pend_vld = 1.
    - On fsx_fall, go to ST_DONE.
  - ST_DONE (1 cycle):
    - Pulse slave_rx_frame_done_o.
    - slave_rx_byte_num_o = byte_num.
    - slave_rx_frame_err_o = (bit_cnt != 0) or (pend_vld == 0).
    - slave_rx_crc_err_o = pend_vld and (pend_byte != crc) and not frame_err.
    - The pending byte is never output: it is the CRC byte.
    - Return to ST_IDLE.
  - Output holding: byte_num, crc_err and frame_err hold their values until the next entry into ST_RX.
- Latency:
  - Payload byte k is output one clk_sys_i cycle after the sample of bit 0 of byte k+1.
  - frame_done is output one cycle after fsx_fall is detected.
- Simultaneous events:
  - A byte completion and fsx_fall in the same cycle: complete the byte first, then evaluate in ST_DONE.
  - A clk_rise with FSX low in ST_RX is ignored.
- Boundary cases:
  - Zero-payload frame (CRC byte only): byte_num = 0; crc_err = (byte != 0xFF).
  - FSX pulse with no clock edges: frame_done with frame_err = 1 and byte_num = 0.
- Reset mid-frame: discard all state, raise no strobes, go to ST_FLUSH.

Decomposition:
- Package slave_comm_pkg holds:
  - state encodings: ST_FLUSH, ST_IDLE, ST_RX, ST_DONE;
  - CRC8_INIT = 8'hFF;
  - function nextCRC8D8 (D[7] is the first serial bit), shared with the transmitter.
- One sub-module, slave_comm_rx_sync, holds the SYNC_STAGES synchronisers and the clk_rise/fsx_fall edge detect.

Test Plan:
- Single-byte frame:
  - Stimulus: FSX high, bits 0x00 then 0xF3, FSX low.
  - Required: one data strobe with 0x00; frame_done with byte_num=1, crc_err=0, frame_err=0.
- Zero-payload frame:
  - Stimulus: CRC byte 0xFF only.
  - Required: no data strobe; frame_done, byte_num=0, crc_err=0.
- Corrupted CRC:
  - Stimulus: payload 0x00 then 0xF2.
  - Required: data 0x00 output; crc_err=1, frame_err=0.
- Multi-byte frame:
  - Stimulus: 256 bytes 0x00..0xFF, then the CRC computed by the reference model, at clk_sys/SLAVE_MSG_CLK ratios 4 and 7.
  - Required: 256 strobes in order, byte_num=256, no errors.
- Framing error: FSX drops after 13 bits (one byte + 5 bits) -> no data strobe, frame_err=1, byte_num=0.
- Reset mid-frame:
  - Stimulus: rst_i pulse in the middle of byte 2 while FSX stays high.
  - Required: no strobes until FSX goes low; the next full frame is received correctly.

Source files
------------

// File: rtl/slave_comm_pkg.sv
// Shared definitions for the slave message link: FSM states and the CRC8 used on both ends.
package slave_comm_pkg;

  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RX    = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [7:0] CRC8_INIT = 8'hFF;
  localparam logic [7:0] CRC8_POLY = 8'h07;

  // CRC8 x^8+x^2+x+1 over one byte; d[7] is the first bit on the wire.
  function automatic logic [7:0] nextCRC8D8(input logic [7:0] d, input logic [7:0] crc);
    logic [7:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ CRC8_POLY;
      else             c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/slave_comm_rx_sync.sv
// Synchronisers for the asynchronous link inputs plus bit-clock rise / FSX fall detection.
module slave_comm_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic msg_clk_i,
  input  logic fsx_i,
  input  logic rx_i,
  output logic fsx_s_o,
  output logic rx_s_o,
  output logic clk_rise_c,
  output logic fsx_fall_c
);

  localparam int unsigned MSB = SYNC_STAGES - 1;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] fsx_sync_q, fsx_sync_d;
  logic [SYNC_STAGES-1:0] rx_sync_q,  rx_sync_d;
  logic                   clk_dly_q,  clk_dly_d;
  logic                   fsx_dly_q,  fsx_dly_d;

  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], msg_clk_i};
    fsx_sync_d = {fsx_sync_q[SYNC_STAGES-2:0], fsx_i};
    rx_sync_d  = {rx_sync_q[SYNC_STAGES-2:0],  rx_i};
    clk_dly_d  = clk_sync_q[MSB];
    fsx_dly_d  = fsx_sync_q[MSB];
  end

  // Not reset: after a reset the FSM must still see FSX high to flush a frame in flight.
  always_ff @(posedge clk) begin
    clk_sync_q <= clk_sync_d;
    fsx_sync_q <= fsx_sync_d;
    rx_sync_q  <= rx_sync_d;
    clk_dly_q  <= clk_dly_d;
    fsx_dly_q  <= fsx_dly_d;
  end

  assign fsx_s_o    = fsx_sync_q[MSB];
  assign rx_s_o     = rx_sync_q[MSB];
  assign clk_rise_c = clk_sync_q[MSB] & ~clk_dly_q;
  assign fsx_fall_c = ~fsx_sync_q[MSB] & fsx_dly_q;

endmodule

// File: rtl/slave_comm_rx.sv
// Slave message link receiver: deserialises MSB-first bytes, holds back the trailing CRC byte
// and reports payload bytes plus frame status in the system clock domain.
module slave_comm_rx
  import slave_comm_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned BYTE_NUM_W  = 16
) (
  input  logic                  clk_sys_i,
  input  logic                  rst_i,
  input  logic                  SLAVE_MSG_CLK,
  input  logic                  SLAVE_MSG_RX_FSX,
  input  logic                  SLAVE_MSG_RX,
  output logic                  slave_rx_data_vld_o,
  output logic [7:0]            slave_rx_data_o,
  output logic                  slave_rx_frame_done_o,
  output logic [BYTE_NUM_W-1:0] slave_rx_byte_num_o,
  output logic                  slave_rx_crc_err_o,
  output logic                  slave_rx_frame_err_o,
  output logic                  slave_rx_busy_o
);

  logic fsx_s, rx_s, clk_rise_c, fsx_fall_c;

  slave_comm_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk_sys_i),
    .msg_clk_i  (SLAVE_MSG_CLK),
    .fsx_i      (SLAVE_MSG_RX_FSX),
    .rx_i       (SLAVE_MSG_RX),
    .fsx_s_o    (fsx_s),
    .rx_s_o     (rx_s),
    .clk_rise_c (clk_rise_c),
    .fsx_fall_c (fsx_fall_c)
  );

  state_e                state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            sh_q, sh_d;
  logic [7:0]            pend_byte_q, pend_byte_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [7:0]            crc_q, crc_d;
  logic [BYTE_NUM_W-1:0] byte_num_q, byte_num_d;
  logic                  data_vld_q, data_vld_d;
  logic [7:0]            data_q, data_d;
  logic                  frame_done_q, frame_done_d;
  logic [BYTE_NUM_W-1:0] byte_num_out_q, byte_num_out_d;
  logic                  crc_err_q, crc_err_d;
  logic                  frame_err_q, frame_err_d;
  logic                  busy_q, busy_d;
  logic                  sample;
  logic [7:0]            nxt_byte;

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    sh_d           = sh_q;
    pend_byte_d    = pend_byte_q;
    pend_vld_d     = pend_vld_q;
    crc_d          = crc_q;
    byte_num_d     = byte_num_q;
    data_vld_d     = 1'b0;
    data_d         = data_q;
    frame_done_d   = 1'b0;
    byte_num_out_d = byte_num_out_q;
    crc_err_d      = crc_err_q;
    frame_err_d    = frame_err_q;
    sample         = 1'b0;
    nxt_byte       = 8'h00;

    case (state_q)
      ST_FLUSH: if (!fsx_s) state_d = ST_IDLE;
      ST_IDLE: begin
        // FSX alone opens a frame so an edgeless FSX pulse still reports a framing error.
        if (fsx_s) begin
          state_d        = ST_RX;
          bit_cnt_d      = 3'd0;
          sh_d           = 8'h00;
          pend_byte_d    = 8'h00;
          pend_vld_d     = 1'b0;
          crc_d          = CRC8_INIT;
          byte_num_d     = '0;
          byte_num_out_d = '0;
          crc_err_d      = 1'b0;
          frame_err_d    = 1'b0;
          sample         = clk_rise_c;
        end
      end
      ST_RX: begin
        sample = clk_rise_c & fsx_s;
        if (fsx_fall_c) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_FLUSH;
    endcase

    if (sample) begin
      nxt_byte = {sh_d[6:0], rx_s};
      sh_d     = nxt_byte;
      if (bit_cnt_d == 3'd7) begin
        if (pend_vld_d) begin
          data_vld_d = 1'b1;
          data_d     = pend_byte_d;
          crc_d      = nextCRC8D8(pend_byte_d, crc_d);
          if (byte_num_d != '1) byte_num_d = byte_num_d + BYTE_NUM_W'(1);
        end
        pend_byte_d = nxt_byte;
        pend_vld_d  = 1'b1;
      end
      bit_cnt_d = bit_cnt_d + 3'd1;
    end

    // Status is evaluated on the post-sample values so a byte finishing with FSX is counted.
    if (state_q == ST_RX && fsx_fall_c) begin
      frame_done_d   = 1'b1;
      byte_num_out_d = byte_num_d;
      frame_err_d    = (bit_cnt_d != 3'd0) | ~pend_vld_d;
      crc_err_d      = pend_vld_d & (pend_byte_d != crc_d) & ~frame_err_d;
    end

    busy_d = (state_d == ST_RX);
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      state_q        <= ST_FLUSH;
      bit_cnt_q      <= 3'd0;
      sh_q           <= 8'h00;
      pend_byte_q    <= 8'h00;
      pend_vld_q     <= 1'b0;
      crc_q          <= CRC8_INIT;
      byte_num_q     <= '0;
      data_vld_q     <= 1'b0;
      data_q         <= 8'h00;
      frame_done_q   <= 1'b0;
      byte_num_out_q <= '0;
      crc_err_q      <= 1'b0;
      frame_err_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      sh_q           <= sh_d;
      pend_byte_q    <= pend_byte_d;
      pend_vld_q     <= pend_vld_d;
      crc_q          <= crc_d;
      byte_num_q     <= byte_num_d;
      data_vld_q     <= data_vld_d;
      data_q         <= data_d;
      frame_done_q   <= frame_done_d;
      byte_num_out_q <= byte_num_out_d;
      crc_err_q      <= crc_err_d;
      frame_err_q    <= frame_err_d;
      busy_q         <= busy_d;
    end
  end

  assign slave_rx_data_vld_o   = data_vld_q;
  assign slave_rx_data_o       = data_q;
  assign slave_rx_frame_done_o = frame_done_q;
  assign slave_rx_byte_num_o   = byte_num_out_q;
  assign slave_rx_crc_err_o    = crc_err_q;
  assign slave_rx_frame_err_o  = frame_err_q;
  assign slave_rx_busy_o       = busy_q;

endmodule
